bus_transfer_sequencer: RTL and testbench

BUS_TRANSFER_SEQUENCER -- requirements
Module: bus_transfer_sequencer

---
 rtl/bus_transfer_sequencer.sv | 138 +++++++++++++
 tb/tb_bus_transfer_sequencer.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bus_transfer_sequencer.sv
// Sequences register-to-register transfers over a shared bus: queued requests
// are played out as DRIVE (source enabled), LATCH (destination strobed), RELEASE.
module bus_transfer_sequencer #(
    parameter int NREG  = 8,
    parameter int WIDTH = 8,
    localparam int IW   = $clog2(NREG)
) (
    input  logic             clk,
    input  logic             reset_n,
    // Handshake: a request transfers on a rising edge where req_valid and
    // req_ready are both 1; req_ready depends only on registered occupancy.
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [IW-1:0]    req_src,
    input  logic [IW-1:0]    req_dst,
    input  logic             req_capture,
    input  logic [WIDTH-1:0] bus_in,
    output logic [NREG-1:0]  reg_enable,
    output logic [NREG-1:0]  reg_latch,
    output logic [WIDTH-1:0] capture_data,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [1:0]       fsm_state
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_DRIVE   = 2'd1,
        S_LATCH   = 2'd2,
        S_RELEASE = 2'd3
    } state_t;

    state_t state, state_next;

    logic [IW-1:0] fifo_src [4];
    logic [IW-1:0] fifo_dst [4];
    logic          fifo_cap [4];
    logic [1:0]    wr_ptr, rd_ptr;
    logic [2:0]    count;

    logic [IW-1:0] act_src, act_dst;
    logic          act_cap;

    logic          accept, push, reject, pop;
    logic [IW-1:0] next_src;

    assign req_ready = (count < 3'd4);
    assign accept    = req_valid & req_ready;
    assign push      = accept & (req_src != req_dst);
    assign reject    = accept & (req_src == req_dst);
    assign busy      = (state != S_IDLE) || (count != 3'd0);
    assign fsm_state = state;

    always_comb begin
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (count != 3'd0) begin
                    state_next = S_DRIVE;
                    pop        = 1'b1;
                end
            end
            S_DRIVE: state_next = S_LATCH;
            S_LATCH: state_next = S_RELEASE;
            S_RELEASE: begin
                if (count != 3'd0) begin
                    state_next = S_DRIVE;
                    pop        = 1'b1;
                end else begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // The source for the coming cycle is the FIFO head when popping, so the
    // registered enable lines up with the first DRIVE cycle.
    assign next_src = pop ? fifo_src[rd_ptr] : act_src;

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_src[wr_ptr] <= req_src;
            fifo_dst[wr_ptr] <= req_dst;
            fifo_cap[wr_ptr] <= req_capture;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= 2'd0;
            rd_ptr <= 2'd0;
            count  <= 3'd0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 2'd1;
            if (pop)  rd_ptr <= rd_ptr + 2'd1;
            unique case ({push, pop})
                2'b10:   count <= count + 3'd1;
                2'b01:   count <= count - 3'd1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            act_src <= '0;
            act_dst <= '0;
            act_cap <= 1'b0;
        end else if (pop) begin
            act_src <= fifo_src[rd_ptr];
            act_dst <= fifo_dst[rd_ptr];
            act_cap <= fifo_cap[rd_ptr];
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= S_IDLE;
            reg_enable   <= '0;
            reg_latch    <= '0;
            done         <= 1'b0;
            err          <= 1'b0;
            capture_data <= '0;
        end else begin
            state      <= state_next;
            reg_enable <= (state_next == S_DRIVE || state_next == S_LATCH)
                          ? (NREG'(1) << next_src) : '0;
            reg_latch  <= (state_next == S_LATCH) ? (NREG'(1) << act_dst) : '0;
            done       <= (state_next == S_RELEASE);
            err        <= reject;
            if (state == S_LATCH && act_cap) capture_data <= bus_in;
        end
    end

endmodule

// File: tb/tb_bus_transfer_sequencer.sv
// Bench for bus_transfer_sequencer: directed literal scenarios plus randomized
// traffic compared each cycle against a queue-based transfer model.
module tb_bus_transfer_sequencer;

    logic       clk;
    logic       reset_n;
    logic       req_valid;
    logic       req_ready;
    logic [2:0] req_src, req_dst;
    logic       req_capture;
    logic [7:0] bus_in;
    logic [7:0] reg_enable, reg_latch, capture_data;
    logic       busy, done, err;
    logic [1:0] fsm_state;

    bus_transfer_sequencer #(.NREG(8), .WIDTH(8)) dut (
        .clk(clk), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_src(req_src), .req_dst(req_dst), .req_capture(req_capture),
        .bus_in(bus_in), .reg_enable(reg_enable), .reg_latch(reg_latch),
        .capture_data(capture_data), .busy(busy), .done(done), .err(err),
        .fsm_state(fsm_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 0;
    int cyc = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Model: pending transfers in a queue; the active one is tracked only by
    // its age in cycles (1 = source driven, 2 = destination latching, 3 = done).
    typedef struct packed {
        logic [2:0] src;
        logic [2:0] dst;
        logic       cap;
    } req_t;

    req_t       m_q[$];
    req_t       m_act;
    int         m_age;
    logic [7:0] m_cap_data;
    logic       m_err;
    bit         m_acc;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_q.delete();
            m_act      = '0;
            m_age      = 0;
            m_cap_data = 8'h00;
            m_err      = 1'b0;
        end else begin
            m_acc = req_valid && (m_q.size() < 4);
            if (m_age == 2 && m_act.cap) m_cap_data = bus_in;
            if ((m_age == 0 || m_age == 3) && m_q.size() != 0) begin
                m_act = m_q.pop_front();
                m_age = 1;
            end else if (m_age == 3) begin
                m_age = 0;
            end else if (m_age != 0) begin
                m_age = m_age + 1;
            end
            m_err = m_acc && (req_src == req_dst);
            if (m_acc && req_src != req_dst) m_q.push_back('{req_src, req_dst, req_capture});
        end
    end

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        if (reset_n && chk_en) begin
            check("ready", req_ready, m_q.size() < 4);
            check("busy", busy, (m_age != 0) || (m_q.size() != 0));
            check("enable", reg_enable, (m_age == 1 || m_age == 2) ? (8'd1 << m_act.src) : 8'd0);
            check("latch", reg_latch, (m_age == 2) ? (8'd1 << m_act.dst) : 8'd0);
            check("done", done, m_age == 3);
            check("err", err, m_err);
            check("capture", capture_data, m_cap_data);
            check("inv_en_onehot", $countones(reg_enable) <= 1, 1);
            check("inv_latch_onehot", $countones(reg_latch) <= 1, 1);
            check("inv_latch_needs_en", (reg_latch != 0) && (reg_enable == 0), 0);
        end
    end

    int done_times[$];
    int busy_fall;
    logic busy_prev = 1'b0;
    always @(negedge clk) begin
        if (reset_n && done === 1'b1) done_times.push_back(cyc);
        if (reset_n && busy_prev && !busy) busy_fall = cyc;
        busy_prev = busy;
    end

    task automatic send(input logic [2:0] s, input logic [2:0] d, input logic c, input logic [7:0] b);
        req_valid   = 1'b1;
        req_src     = s;
        req_dst     = d;
        req_capture = c;
        bus_in      = b;
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        req_valid = 1'b0;
        while ((m_q.size() != 0 || m_age != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("idle_timeout", n >= 200, 0);
        @(negedge clk);
    endtask

    task automatic drive_random_distinct();
        logic [2:0] s;
        s           = 3'($urandom_range(0, 7));
        req_valid   = 1'b1;
        req_src     = s;
        req_dst     = s + 3'($urandom_range(1, 7));
        req_capture = 1'($urandom_range(0, 1));
        bus_in      = 8'($urandom_range(0, 255));
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, acc, dens;
        reset_n = 1'b1;
        req_valid = 1'b0; req_src = 3'd0; req_dst = 3'd0; req_capture = 1'b0; bus_in = 8'h00;
        #2 reset_n = 1'b0;
        #1;
        check("rst_enable", reg_enable, 8'h00);
        check("rst_latch", reg_latch, 8'h00);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_capture", capture_data, 8'h00);
        check("rst_busy", busy, 0);
        check("rst_state", fsm_state, 2'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        chk_en  = 1'b1;
        #1 check("ready_after_reset", req_ready, 1);
        @(negedge clk);

        // Single transfer src=2 dst=5 with capture of 8'hA7
        send(3'd2, 3'd5, 1'b1, 8'hA7);
        check("single_c0_busy", busy, 1);
        check("single_c0_enable", reg_enable, 8'h00);
        @(negedge clk);
        check("single_c1_enable", reg_enable, 8'h04);
        check("single_c1_latch", reg_latch, 8'h00);
        @(negedge clk);
        check("single_c2_enable", reg_enable, 8'h04);
        check("single_c2_latch", reg_latch, 8'h20);
        @(negedge clk);
        check("single_c3_enable", reg_enable, 8'h00);
        check("single_c3_done", done, 1);
        check("single_capture", capture_data, 8'hA7);
        @(negedge clk);
        check("single_c4_done", done, 0);
        check("single_c4_busy", busy, 0);

        // Capture 8'h5C, then a no-capture transfer must leave it intact
        send(3'd1, 3'd4, 1'b1, 8'h5C);
        wait_idle();
        check("cap_5c", capture_data, 8'h5C);
        send(3'd6, 3'd0, 1'b0, 8'h11);
        wait_idle();
        check("nocap_holds", capture_data, 8'h5C);

        // Rejected request src == dst
        send(3'd3, 3'd3, 1'b1, 8'h33);
        check("reject_err", err, 1);
        check("reject_busy", busy, 0);
        check("reject_ready", req_ready, 1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("reject_no_err", err, 0);
            check("reject_no_done", done, 0);
            check("reject_no_enable", reg_enable, 8'h00);
        end

        // Five back-to-back requests
        done_times.delete();
        busy_fall = -1;
        acc = 0; n = 0;
        while (acc < 5 && n < 50) begin
            drive_random_distinct();
            if (req_ready) acc++;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        n = 0;
        while (done_times.size() < 5 && n < 60) begin
            @(negedge clk);
            n++;
        end
        @(negedge clk);
        check("burst_done_count", done_times.size(), 5);
        if (done_times.size() == 5) begin
            for (int i = 1; i < 5; i++) check("burst_spacing", done_times[i] - done_times[i-1], 3);
            check("burst_busy_fall", busy_fall, done_times[4] + 1);
        end
        wait_idle();

        // Continuous push until the queue fills: 4 held plus the two already popped
        acc = 0; n = 0;
        while (n < 20) begin
            drive_random_distinct();
            if (!req_ready) break;
            acc++;
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check("fill_accepted", acc, 6);
        check("fill_ready_low", req_ready, 0);
        wait_idle();

        // Reset during LATCH with two requests still queued
        send(3'd1, 3'd6, 1'b1, 8'h99);
        send(3'd2, 3'd3, 1'b0, 8'h99);
        send(3'd4, 3'd5, 1'b1, 8'h99);
        check("pre_rst_enable", reg_enable, 8'h02);
        check("pre_rst_latch", reg_latch, 8'h40);
        #2 reset_n = 1'b0;
        #1;
        check("midrst_enable", reg_enable, 8'h00);
        check("midrst_latch", reg_latch, 8'h00);
        check("midrst_busy", busy, 0);
        check("midrst_capture", capture_data, 8'h00);
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("postrst_done", done, 0);
            check("postrst_busy", busy, 0);
            check("postrst_state", fsm_state, 2'd0);
        end

        // Randomized traffic
        dens = 50;
        for (int c = 0; c < 2000; c++) begin
            if (c % 200 == 0) dens = $urandom_range(10, 100);
            req_valid   = ($urandom_range(0, 99) < dens);
            req_src     = 3'($urandom_range(0, 7));
            req_dst     = ($urandom_range(0, 7) == 0) ? req_src : 3'($urandom_range(0, 7));
            req_capture = 1'($urandom_range(0, 1));
            bus_in      = 8'($urandom_range(0, 255));
            @(negedge clk);
        end
        wait_idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
